// File: rtl/moore_seq_detector_param.sv
// moore_seq_detector_param: Moore serial pattern detector with prefix-fallback transitions and a saturating match counter
module moore_seq_detector_param #(
  parameter int                   PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_WIDTH = 8,
  localparam int                  SW        = $clog2(PAT_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 din,
  output logic                 detected,
  output logic [SW-1:0]        state_dbg,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 count_sat
);
  typedef enum logic [SW-1:0] {S0 = '0, MATCH = SW'(PAT_WIDTH)} state_t;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [SW-1:0]        w_nxt [2**SW][2];
  logic [SW-1:0]        w_next;
  // Longest suffix of (first k pattern bits, then b) that is also a pattern prefix
  function automatic int kmp_next(int k, logic b);
    int   best;
    int   m;
    logic ok;
    logic c;
    best = 0;
    if (k > PAT_WIDTH) return 0;
    if (k == PAT_WIDTH && !OVERLAP) return (b == PATTERN[PAT_WIDTH-1]) ? 1 : 0;
    for (int j = 1; j <= PAT_WIDTH; j++) begin
      ok = (j <= k + 1);
      for (int i = 0; i < j; i++) begin
        if (ok) begin
          m  = k + 1 - j + i;
          c  = (m < k) ? PATTERN[PAT_WIDTH-1-m] : b;
          ok = (c == PATTERN[PAT_WIDTH-1-i]);
        end
      end
      if (ok) best = j;
    end
    return best;
  endfunction
  always_comb begin
    for (int k = 0; k < 2**SW; k++)
      for (int b = 0; b < 2; b++)
        w_nxt[k][b] = SW'(kmp_next(k, 1'(b)));
  end
  assign w_next = w_nxt[r_state][din];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_count <= '0;
    end else if (clear) begin
      r_state <= S0;
      r_count <= '0;
    end else if (en) begin
      r_state <= state_t'(w_next);
      if (w_next == MATCH && !(&r_count)) r_count <= r_count + 1'b1;
    end
  end
  assign detected    = (r_state == MATCH);
  assign state_dbg   = r_state;
  assign match_count = r_count;
  assign count_sat   = &r_count;
endmodule

// File: tb/tb_moore_seq_detector_param.sv
// tb_moore_seq_detector_param: overlap, non-overlap and 2-bit-counter instances checked against a suffix-matching history model
module tb_moore_seq_detector_param;
  localparam int         P   = 4;
  localparam logic [3:0] PAT = 4'b1011;
  logic clk = 0, rst_n = 0, clear = 0, en = 0, din = 0;
  logic [2:0] st0, st1, st2;
  logic       det0, det1, det2, sat0, sat1, sat2;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;
  int n_cmp = 0, n_bad = 0;

  moore_seq_detector_param #(.PAT_WIDTH(P), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .din(din),
    .detected(det0), .state_dbg(st0), .match_count(mc0), .count_sat(sat0));
  moore_seq_detector_param #(.PAT_WIDTH(P), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .din(din),
    .detected(det1), .state_dbg(st1), .match_count(mc1), .count_sat(sat1));
  moore_seq_detector_param #(.PAT_WIDTH(P), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .din(din),
    .detected(det2), .state_dbg(st2), .match_count(mc2), .count_sat(sat2));

  always #5 clk = ~clk;

  typedef struct {int hist; int len; int st; int cnt;} model_t;
  model_t md[3];
  int ov[3]   = '{1, 0, 1};
  int cmax[3] = '{255, 255, 3};

  typedef struct {logic en; logic din; int st0; int cnt0; int st1; int cnt1;} vec_t;
  vec_t tv[7];

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) md[i] = '{0, 0, 0, 0};
  endtask

  // State = longest suffix of the bits seen since the last restart that is a pattern prefix
  task automatic model_edge(input logic c, input logic e, input logic d);
    for (int i = 0; i < 3; i++) begin
      if (c) md[i] = '{0, 0, 0, 0};
      else if (e) begin
        md[i].hist = ((md[i].hist << 1) | int'(d)) & ((1 << P) - 1);
        md[i].len  = (md[i].len < P) ? md[i].len + 1 : P;
        md[i].st   = 0;
        for (int j = 1; j <= P; j++)
          if (j <= md[i].len && (md[i].hist & ((1 << j) - 1)) == (int'(PAT) >> (P - j))) md[i].st = j;
        if (md[i].st == P) begin
          if (md[i].cnt < cmax[i]) md[i].cnt++;
          if (ov[i] == 0) md[i].len = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string nm);
    int s[3], c[3], d[3], t[3];
    s = '{int'(st0), int'(st1), int'(st2)};
    c = '{int'(mc0), int'(mc1), int'(mc2)};
    d = '{int'(det0), int'(det1), int'(det2)};
    t = '{int'(sat0), int'(sat1), int'(sat2)};
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("%s.u%0d.state", nm, i), s[i], md[i].st);
      cmp($sformatf("%s.u%0d.det", nm, i), d[i], int'(md[i].st == P));
      cmp($sformatf("%s.u%0d.count", nm, i), c[i], md[i].cnt);
      cmp($sformatf("%s.u%0d.sat", nm, i), t[i], int'(md[i].cnt == cmax[i]));
    end
  endtask

  task automatic tick(input logic c, input logic e, input logic d);
    clear = c; en = e; din = d;
    @(posedge clk);
    model_edge(c, e, d);
    #1;
  endtask

  initial begin
    logic [3:0] seq;
    seq = PAT;
    tv[0] = '{1'b1, 1'b1, 1, 0, 1, 0};
    tv[1] = '{1'b1, 1'b0, 2, 0, 2, 0};
    tv[2] = '{1'b1, 1'b1, 3, 0, 3, 0};
    tv[3] = '{1'b1, 1'b1, 4, 1, 4, 1};
    tv[4] = '{1'b1, 1'b0, 2, 1, 0, 1};
    tv[5] = '{1'b1, 1'b1, 3, 1, 1, 1};
    tv[6] = '{1'b1, 1'b1, 4, 2, 1, 1};

    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear = 1'($urandom); en = 1'($urandom); din = 1'($urandom);
    end
    @(negedge clk);
    clear = 0; en = 0; din = 0; rst_n = 1;
    #1;
    cmp("reset.det", int'(det0), 0);
    cmp("reset.state", int'(st0), 0);
    cmp("reset.count", int'(mc0), 0);
    cmp("reset.sat", int'(sat0), 0);
    check_model("reset");

    foreach (tv[i]) begin
      tick(1'b0, tv[i].en, tv[i].din);
      cmp($sformatf("vec%0d.st_ov", i), int'(st0), tv[i].st0);
      cmp($sformatf("vec%0d.det_ov", i), int'(det0), int'(tv[i].st0 == P));
      cmp($sformatf("vec%0d.cnt_ov", i), int'(mc0), tv[i].cnt0);
      cmp($sformatf("vec%0d.st_nov", i), int'(st1), tv[i].st1);
      cmp($sformatf("vec%0d.det_nov", i), int'(det1), int'(tv[i].st1 == P));
      cmp($sformatf("vec%0d.cnt_nov", i), int'(mc1), tv[i].cnt1);
      check_model($sformatf("vec%0d", i));
    end

    tick(1'b1, 1'b1, 1'b1);
    check_model("clr_gate");
    for (int b = 3; b >= 0; b--) begin
      tick(1'b0, 1'b1, seq[b]);
      check_model("gate_bit");
      for (int g = 0; g < 3; g++) begin
        tick(1'b0, 1'b0, 1'($urandom));
        check_model("gate_idle");
        if (b == 0) cmp("gate_hold_det", int'(det0), 1);
      end
    end
    cmp("gate_count", int'(mc0), 1);

    tick(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++)
      for (int b = 3; b >= 0; b--) begin
        tick(1'b0, 1'b1, seq[b]);
        check_model("sat");
      end
    cmp("sat_count2", int'(mc2), 3);
    cmp("sat_flag2", int'(sat2), 1);
    cmp("sat_count8", int'(mc0), 5);
    cmp("sat_count8_nov", int'(mc1), 5);

    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    cmp("abort_pre_state", int'(st0), 3);
    rst_n = 0;
    #1;
    cmp("abort_async_state", int'(st0), 0);
    model_reset();
    check_model("abort_rst");
    #2 rst_n = 1;
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    cmp("clr_win_det", int'(det0), 0);
    cmp("clr_win_count", int'(mc0), 0);
    cmp("clr_win_state", int'(st0), 0);
    check_model("clr_win");

    for (int n = 0; n < 3000; n++) begin
      tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/moore_seq_detector_param.md
# moore_seq_detector_param

Parametrised Moore-type serial sequence detector: samples one bit per enabled clock, tracks the longest matched prefix of a compile-time pattern, and asserts a registered, state-decoded `detected` flag when the full pattern has been received. This generation adds a configurable pattern width and value, selectable overlapping or non-overlapping matching, a sample-enable qualifier, a synchronous clear, and a saturating match counter. It sits between a serial bit source (shift register or UART-style deserialiser) and control logic that needs a clean, glitch-free match indication.

## Interface
- `PAT_WIDTH`, 4: pattern length in bits, ≥2.
- `PATTERN`, 4'b1011: target sequence; `PATTERN[PAT_WIDTH-1]` is the first bit received (MSB-first).
- `OVERLAP`, 1: 1 means matches may share bits; 0 means matching restarts fresh after each detection.
- `CNT_WIDTH`, 8: width of the match counter.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous clear of the state and the counter.
- `en`  input  1  sample qualifier; `din` is consumed only when `en`=1.
- `din`  input  1  serial data bit.
- `detected`  output  1  Moore output; high while the FSM is in state MATCH.
- `state_dbg`  output  clog2(PAT_WIDTH+1)  current state index (matched prefix length).
- `match_count`  output  CNT_WIDTH  number of detections since reset or clear.
- `count_sat`  output  1  high when `match_count` equals all-ones.

## Operation
- States S0..S(PAT_WIDTH). Sk means the last k sampled bits equal the first k pattern bits. S(PAT_WIDTH) = MATCH.
- `detected` = (state == MATCH). It is decoded from the state register only, never from `din`.
- Next state from Sk, k<PAT_WIDTH, on a sampled bit b: the longest suffix of (matched prefix k, then b) that is also a pattern prefix. This is KMP failure behaviour, computed combinationally from `PATTERN` using loops or a generate block. No hard-coded per-pattern tables.
- From MATCH with `OVERLAP`=1: apply the same rule using the full pattern as the prefix.
- From MATCH with `OVERLAP`=0: next state = S1 if b equals the first pattern bit, else S0.
- `en`=0: state and counter hold. If the FSM holds in MATCH, `detected` stays high.
- `match_count` increments by 1 on every transition into MATCH, including MATCH→MATCH in overlap mode with a periodic pattern. It saturates at 2^CNT_WIDTH−1 and does not wrap.
- Priority, highest first: `rst_n` low, then `clear`, then `en`.
- `clear`=1 forces state S0 and `match_count` 0 at the next edge, regardless of `en` and `din`.

## Timing
- Reset values: state S0, `detected`=0, `state_dbg`=0, `match_count`=0, `count_sat`=0.
- Asserting `rst_n` low takes effect immediately, mid-sequence included. The first sample after deassertion is taken at the first rising edge with `en`=1.
- Latency: the edge that samples the final pattern bit loads MATCH. `detected` is high in the cycle following that edge. `match_count` updates at the same edge.
- With continuous `en`=1, `detected` pulses for exactly one cycle per detection, unless the next bit re-enters MATCH.
- All outputs are registered or pure state decodes. There is no combinational path from `din`, `en` or `clear` to any output.
- `clear` together with a completing bit: the clear wins. The counter is 0 and the state is S0.

## Test plan
- Reset: hold `rst_n`=0 with toggling inputs, then release. Required: `detected`=0, `state_dbg`=0, `match_count`=0, `count_sat`=0.
- Single match, defaults: `en`=1, `din` = 1,0,1,1 on four edges. Required: `detected` high for one cycle immediately after the 4th edge, `match_count`=1, `state_dbg` sequence 1,2,3,4.
- Overlap vs non-overlap: stream 1,0,1,1,0,1,1.
  - `OVERLAP`=1: detections after bits 4 and 7, `match_count`=2.
  - `OVERLAP`=0: detection after bit 4 only, `match_count`=1.
- Enable gating: feed 1,0,1,1 with 3 `en`=0 cycles between each bit while `din` toggles randomly. Required: same single detection, with `detected` held high through the `en`=0 cycles that follow MATCH.
- Saturation: `CNT_WIDTH`=2, PATTERN=1011, five disjoint 1011 groups. Required: `match_count`=3, `count_sat`=1, and no wrap.
- Mid-sequence abort:
  - After 1,0,1, pulse `rst_n` low asynchronously between edges. Required: `state_dbg`=0 immediately.
  - Repeat the same sequence using `clear` with the 4th bit `din`=1 on the same edge. Required: no detection, `match_count`=0.
